// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared snake-game coordinate type, spawn states and grid defaults
package snake_pkg;

    typedef logic [9:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE_X,
        SAMPLE_Y,
        QUERY,
        WAIT,
        SCAN,
        FAIL
    } spawn_state_t;

    localparam int unsigned DEF_GRID_W = 40;
    localparam int unsigned DEF_GRID_H = 30;

    // A limit of 1024 admits every 10-bit value.
    function automatic logic in_grid(coord_t v, int unsigned lim);
        return {22'd0, v} < lim;
    endfunction

endpackage

// File: rtl/food_spawn_ctrl_if.sv
// rtl/food_spawn_ctrl_if.sv - spawn request and occupancy-query signals of food_spawn_ctrl
interface food_spawn_ctrl_if;
    import snake_pkg::*;

    logic   spawn_req;
    logic   busy;
    logic   done;
    logic   done_ok;
    coord_t food_x;
    coord_t food_y;
    logic   occ_req;
    coord_t occ_x;
    coord_t occ_y;
    logic   occ_ack;
    logic   occ_hit;

    modport master (
        input  spawn_req, occ_ack, occ_hit,
        output busy, done, done_ok, food_x, food_y, occ_req, occ_x, occ_y
    );

    modport slave (
        output spawn_req, occ_ack, occ_hit,
        input  busy, done, done_ok, food_x, food_y, occ_req, occ_x, occ_y
    );

endinterface

// File: rtl/food_spawn_ctrl_raster_step.sv
// rtl/food_spawn_ctrl_raster_step.sv - next grid cell in raster order with x and y wrap
module raster_step
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W = DEF_GRID_W,
    parameter int unsigned GRID_H = DEF_GRID_H
) (
    input  coord_t x,
    input  coord_t y,
    output coord_t nx,
    output coord_t ny
);

    localparam coord_t LAST_X = coord_t'(GRID_W - 1);
    localparam coord_t LAST_Y = coord_t'(GRID_H - 1);

    always_comb begin
        nx = x + 10'd1;
        ny = y;
        if (x == LAST_X) begin
            nx = '0;
            ny = (y == LAST_Y) ? '0 : y + 10'd1;
        end
    end

endmodule

// File: rtl/food_spawn_ctrl.sv
// rtl/food_spawn_ctrl.sv - picks a free food cell by rejection sampling plus occupancy checks; FOOD_SCAN_FALLBACK_EN adds a raster scan after exhaustion
module food_spawn_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W    = DEF_GRID_W,
    parameter int unsigned GRID_H    = DEF_GRID_H,
    parameter int unsigned MAX_TRIES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  coord_t            rnd,
    food_spawn_ctrl_if.master bus
);

    localparam logic [7:0] TRY_LIM = 8'(MAX_TRIES);

    spawn_state_t state, state_n;
    coord_t       cand_x, cand_x_n, cand_y, cand_y_n;
    coord_t       food_x, food_x_n, food_y, food_y_n;
    logic [7:0]   tries, tries_n, tries_inc;
    logic         occ_req, occ_req_n;
    logic         done, done_n, done_ok, done_ok_n;

`ifdef FOOD_SCAN_FALLBACK_EN
    coord_t start_x, start_x_n, start_y, start_y_n;
    coord_t step_x, step_y;
    logic   scanning, scanning_n;

    raster_step #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_raster_step (
        .x  (cand_x),
        .y  (cand_y),
        .nx (step_x),
        .ny (step_y)
    );
`endif

    assign tries_inc = (tries == TRY_LIM) ? tries : tries + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cand_x   <= '0;
            cand_y   <= '0;
            food_x   <= '0;
            food_y   <= '0;
            tries    <= '0;
            occ_req  <= 1'b0;
            done     <= 1'b0;
            done_ok  <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
            start_x  <= '0;
            start_y  <= '0;
            scanning <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cand_x   <= cand_x_n;
            cand_y   <= cand_y_n;
            food_x   <= food_x_n;
            food_y   <= food_y_n;
            tries    <= tries_n;
            occ_req  <= occ_req_n;
            done     <= done_n;
            done_ok  <= done_ok_n;
`ifdef FOOD_SCAN_FALLBACK_EN
            start_x  <= start_x_n;
            start_y  <= start_y_n;
            scanning <= scanning_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        cand_x_n   = cand_x;
        cand_y_n   = cand_y;
        food_x_n   = food_x;
        food_y_n   = food_y;
        tries_n    = tries;
        occ_req_n  = occ_req;
        done_n     = 1'b0;
        done_ok_n  = 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
        start_x_n  = start_x;
        start_y_n  = start_y;
        scanning_n = scanning;
`endif
        case (state)
            IDLE: begin
                if (bus.spawn_req) begin
                    state_n = SAMPLE_X;
                    tries_n = '0;
`ifdef FOOD_SCAN_FALLBACK_EN
                    scanning_n = 1'b0;
`endif
                end
            end
            SAMPLE_X: begin
                if (in_grid(rnd, GRID_W)) begin
                    cand_x_n = rnd;
                    state_n  = SAMPLE_Y;
                end
            end
            SAMPLE_Y: begin
                if (in_grid(rnd, GRID_H)) begin
                    cand_y_n = rnd;
                    state_n  = QUERY;
                end
            end
            QUERY: begin
                occ_req_n = 1'b1;
                state_n   = WAIT;
            end
            WAIT: begin
                if (bus.occ_ack) begin
                    occ_req_n = 1'b0;
                    tries_n   = tries_inc;
                    if (!bus.occ_hit) begin
                        food_x_n  = cand_x;
                        food_y_n  = cand_y;
                        done_n    = 1'b1;
                        done_ok_n = 1'b1;
                        state_n   = IDLE;
                    end
`ifdef FOOD_SCAN_FALLBACK_EN
                    else if (scanning) begin
                        state_n = SCAN;
                    end
`endif
                    else if (tries_inc < TRY_LIM) begin
                        state_n = SAMPLE_X;
                    end else begin
`ifdef FOOD_SCAN_FALLBACK_EN
                        // The exhausted candidate is the scan origin; reaching it again means a full grid.
                        state_n    = SCAN;
                        scanning_n = 1'b1;
                        start_x_n  = cand_x;
                        start_y_n  = cand_y;
`else
                        state_n = FAIL;
`endif
                    end
                end
            end
`ifdef FOOD_SCAN_FALLBACK_EN
            SCAN: begin
                cand_x_n = step_x;
                cand_y_n = step_y;
                state_n  = (step_x == start_x && step_y == start_y) ? FAIL : QUERY;
            end
`endif
            FAIL: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done;
    assign bus.done_ok = done_ok;
    assign bus.food_x  = food_x;
    assign bus.food_y  = food_y;
    assign bus.occ_req = occ_req;
    assign bus.occ_x   = cand_x;
    assign bus.occ_y   = cand_y;

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// tb/tb_food_spawn_ctrl.sv - self-checking bench for food_spawn_ctrl
module tb_food_spawn_ctrl;
    import snake_pkg::*;

    typedef struct {
        logic [5:0][9:0] rs;
        int   nr;
        int   nhit;
        int   dly;
        logic ok;
        int   fx, fy, qx, qy, nq, lat;
    } vec_t;

    typedef struct {
        logic ok;
        int   fx, fy, qx, qy, nq, lat;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    coord_t rnd, rnd2;
    int     cyc = 0;
    int     n_tests = 0, n_fail = 0;
    int     t0;

    int     hold = 0, ack_dly = 0;
    int     hits_used = 0, hit_limit = 0;
    int     nq_total = 0, nq_base = 0;
    int     unstable_total = 0, unstable_base = 0;
    int     stray_req = 0, stray_seen = 0;
    coord_t hq_x, hq_y, last_qx, last_qy;
    coord_t q2x[$], q2y[$];
    exp_t   sb[$];
    vec_t   vecs[6];

    food_spawn_ctrl_if bus ();
    food_spawn_ctrl_if bus2 ();

    food_spawn_ctrl #(.GRID_W(40), .GRID_H(30), .MAX_TRIES(4)) dut (
        .clk (clk), .rst (rst), .rnd (rnd), .bus (bus.master)
    );

    food_spawn_ctrl #(.GRID_W(3), .GRID_H(2), .MAX_TRIES(1)) dut2 (
        .clk (clk), .rst (rst), .rnd (rnd2), .bus (bus2.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Occupancy responder for dut: acks ack_dly+1 cycles after occ_req, hits while budget lasts.
    always @(negedge clk) begin
        if (bus.occ_ack === 1'b1) begin
            bus.occ_ack = 1'b0;
            bus.occ_hit = 1'b0;
            hold = 0;
        end else if (bus.occ_req === 1'b1) begin
            if (hold == 0) begin
                hq_x = bus.occ_x;
                hq_y = bus.occ_y;
            end else if (bus.occ_x !== hq_x || bus.occ_y !== hq_y) begin
                unstable_total++;
            end
            if (hold == ack_dly + 1) begin
                bus.occ_ack = 1'b1;
                bus.occ_hit = (hits_used < hit_limit);
                if (hits_used < hit_limit) hits_used++;
                nq_total++;
                last_qx = hq_x;
                last_qy = hq_y;
            end
            hold++;
        end else if (stray_req != stray_seen) begin
            stray_seen = stray_req;
            bus.occ_ack = 1'b1;
            bus.occ_hit = 1'b0;
        end else begin
            bus.occ_ack = 1'b0;
            bus.occ_hit = 1'b0;
            hold = 0;
        end
    end

    // Occupancy map for dut2: only cell (1,0) is free.
    always @(negedge clk) begin
        if (bus2.occ_ack === 1'b1) begin
            bus2.occ_ack = 1'b0;
            bus2.occ_hit = 1'b0;
        end else if (bus2.occ_req === 1'b1) begin
            bus2.occ_ack = 1'b1;
            bus2.occ_hit = !(bus2.occ_x == 10'd1 && bus2.occ_y == 10'd0);
            q2x.push_back(bus2.occ_x);
            q2y.push_back(bus2.occ_y);
        end else begin
            bus2.occ_ack = 1'b0;
            bus2.occ_hit = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic finish_req(input logic seen, input int lat);
        exp_t e;
        chk("done_seen", seen, 1);
        e = sb.pop_front();
        if (seen) begin
            chk("busy_at_done", bus.busy, 0);
            chk("done_ok", bus.done_ok, e.ok);
            chk("food_x", bus.food_x, e.fx);
            chk("food_y", bus.food_y, e.fy);
            chk("last_occ_x", last_qx, e.qx);
            chk("last_occ_y", last_qy, e.qy);
            chk("n_queries", nq_total - nq_base, e.nq);
            chk("query_stable", unstable_total - unstable_base, 0);
            if (e.lat >= 0) chk("latency", lat, e.lat);
        end
        nq_base = nq_total;
        unstable_base = unstable_total;
    endtask

    task automatic run_vec(input vec_t v);
        logic seen = 1'b0;
        int   lat = 0;
        int   idx;
        sb.push_back('{v.ok, v.fx, v.fy, v.qx, v.qy, v.nq, v.lat});
        hit_limit = hits_used + v.nhit;
        ack_dly = v.dly;
        rnd = v.rs[0];
        bus.spawn_req = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            bus.spawn_req = 1'b0;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                lat = cyc - t0;
                break;
            end
            idx = (k < v.nr) ? k : v.nr - 1;
            rnd = v.rs[idx];
        end
        finish_req(seen, lat);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
    endtask

    task automatic wait_done(output logic seen);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic seen;
        int   n_done;
        int   e2x[$], e2y[$];
        logic e2_ok;
        int   e2_fx, e2_fy;

        rst = 1'b0;
        rnd = '0;
        rnd2 = '0;
        bus.spawn_req = 1'b0;
        bus2.spawn_req = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_done_ok", bus.done_ok, 0);
        chk("rst_occ_req", bus.occ_req, 0);
        chk("rst_food", {bus.food_x, bus.food_y}, 0);
        chk("rst_occ_xy", {bus.occ_x, bus.occ_y}, 0);

        rst = 1'b1;
        @(negedge clk);

        vecs[0] = '{{10'd0, 10'd0, 10'd0, 10'd0, 10'd7, 10'd5}, 2, 0, 0, 1'b1, 5, 7, 5, 7, 1, 5};
        vecs[1] = '{{10'd0, 10'd3, 10'd31, 10'd12, 10'd900, 10'd45}, 5, 0, 0, 1'b1, 12, 3, 12, 3, 1, 8};
        vecs[2] = '{{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd9}, 1, 2, 0, 1'b1, 9, 9, 9, 9, 3, 15};
`ifdef FOOD_SCAN_FALLBACK_EN
        vecs[3] = '{{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd21}, 1, 4, 0, 1'b1, 22, 21, 22, 21, 5, 24};
`else
        vecs[3] = '{{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd21}, 1, 99, 0, 1'b0, 9, 9, 21, 21, 4, 21};
`endif
        vecs[4] = '{{10'd0, 10'd0, 10'd0, 10'd0, 10'd29, 10'd33}, 2, 0, 6, 1'b1, 33, 29, 33, 29, 1, 11};
        vecs[5] = '{{10'd0, 10'd0, 10'd29, 10'd30, 10'd39, 10'd40}, 4, 0, 0, 1'b1, 39, 29, 39, 29, 1, 7};

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // spawn_req held across done: re-accepted on the following edge.
        rnd = 10'd11;
        hit_limit = hits_used;
        ack_dly = 0;
        sb.push_back('{1'b1, 11, 11, 11, 11, 1, -1});
        sb.push_back('{1'b1, 11, 11, 11, 11, 1, -1});
        bus.spawn_req = 1'b1;
        wait_done(seen);
        finish_req(seen, 0);
        @(negedge clk);
        chk("b2b_accept", bus.busy, 1);
        bus.spawn_req = 1'b0;
        wait_done(seen);
        finish_req(seen, 0);
        @(negedge clk);

        // Stray ack while idle.
        stray_req++;
        repeat (3) @(negedge clk);
        chk("stray_busy", bus.busy, 0);
        chk("stray_occ_req", bus.occ_req, 0);
        chk("stray_food_x", bus.food_x, 11);

        // dut2 scan fallback on a 3x2 grid.
`ifdef FOOD_SCAN_FALLBACK_EN
        e2x = '{2, 0, 1};
        e2y = '{1, 0, 0};
        e2_ok = 1'b1;
        e2_fx = 1;
        e2_fy = 0;
`else
        e2x = '{2};
        e2y = '{1};
        e2_ok = 1'b0;
        e2_fx = 0;
        e2_fy = 0;
`endif
        rnd2 = 10'd2;
        bus2.spawn_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus2.spawn_req = 1'b0;
        @(negedge clk);
        rnd2 = 10'd1;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus2.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("scan_done_seen", seen, 1);
        chk("scan_done_ok", bus2.done_ok, e2_ok);
        chk("scan_food", {bus2.food_x, bus2.food_y}, {e2_fx[9:0], e2_fy[9:0]});
        chk("scan_n_queries", q2x.size(), e2x.size());
        for (int i = 0; i < e2x.size() && i < q2x.size(); i++) begin
            chk($sformatf("scan_query_%0d", i), {q2x[i], q2y[i]}, {e2x[i][9:0], e2y[i][9:0]});
        end

        // Reset during WAIT aborts without a done pulse.
        @(negedge clk);
        hit_limit = hits_used;
        ack_dly = 30;
        rnd = 10'd4;
        bus.spawn_req = 1'b1;
        @(negedge clk);
        bus.spawn_req = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.occ_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rwait_occ_req_seen", seen, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rwait_occ_req", bus.occ_req, 0);
        chk("rwait_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b1;
        n_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1) n_done++;
        end
        chk("rwait_no_done", n_done, 0);
        chk("rwait_idle", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/food_spawn_ctrl.md
Name: food_spawn_ctrl

Overview:
- Sequences the free-running 10-bit random source (random10) to produce a free food cell for the snake game.
- On a spawn request it draws X then Y by rejection sampling against the grid size.
- Each in-range candidate is checked against the snake-occupancy logic over a req/ack handshake; occupied candidates are retried.
- Sits between the game FSM (requester) and the random source and occupancy map.

Parameters:
- GRID_W, 40, grid width in cells; 1..1024
- GRID_H, 30, grid height in cells; 1..1024
- MAX_TRIES, 64, occupancy checks allowed per request before declaring failure; 1..255

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rnd  in  10  random10 output; changes every clk
- spawn_req  in  1  level; request a new food cell
- busy  out  1  high from request acceptance until done
- done  out  1  one-cycle pulse at end of request
- done_ok  out  1  qualified by done; 1 = food_x/food_y valid
- food_x  out  10  accepted X; held until next acceptance
- food_y  out  10  accepted Y; held until next acceptance
- occ_req  out  1  occupancy query; held until occ_ack
- occ_x  out  10  query X; stable while occ_req
- occ_y  out  10  query Y; stable while occ_req
- occ_ack  in  1  one-cycle response strobe
- occ_hit  in  1  qualified by occ_ack; 1 = cell occupied

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, try counter 0.
- IDLE:
  - spawn_req=1 → SAMPLE_X on the next edge; busy=1 from that edge.
  - spawn_req is ignored while busy.
- SAMPLE_X: register rnd into cand_x if rnd < GRID_W, then go to SAMPLE_Y; otherwise stay and resample next cycle.
- SAMPLE_Y: same rule with GRID_H into cand_y, then go to QUERY. X and Y are always taken from different cycles.
- Rejection sampling does not consume tries. If GRID_W or GRID_H equals 1024, every sample is accepted.
- QUERY:
  - Drive occ_req=1, occ_x=cand_x, occ_y=cand_y; go to WAIT.
  - occ_req stays asserted and the query coordinates stay stable until occ_ack.
- WAIT, on occ_ack:
  - occ_req drops on the same edge; tries increments.
  - occ_hit=0: food_x/food_y <= candidate; done=1, done_ok=1 next cycle; go to IDLE.
  - occ_hit=1 and tries+1 < MAX_TRIES: go to SAMPLE_X.
  - occ_hit=1 and tries+1 == MAX_TRIES: go to FAIL, or SCAN when the optional feature is enabled.
- FAIL: pulse done=1, done_ok=0; food_x/food_y unchanged; go to IDLE.
- busy falls on the same edge on which done rises. tries clears on each accepted request.
- Throughput:
  - Minimum request-to-done latency is 5 cycles when both samples are in range and occ_ack arrives in the cycle after occ_req.
  - A new spawn_req held high across done is accepted on the edge after done.
- An occ_ack outside WAIT is ignored.
- Reset mid-operation aborts immediately: occ_req drops, and no done pulse is generated.
- Width rule: all comparisons are unsigned 10-bit. Counters are 8-bit and saturate at MAX_TRIES.

Optional Feature:
- Macro: FOOD_SCAN_FALLBACK_EN
- Enabled: exhausting tries enters SCAN instead of FAIL.
  - SCAN advances from the last candidate in raster order: x+1, wrapping to 0 with y+1; y wraps from GRID_H-1 to 0.
  - Each cell is queried through the same QUERY/WAIT handshake.
  - The first free cell is reported with done_ok=1.
  - If the scan returns to its start cell with every cell occupied, done with done_ok=0.
- Disabled: SCAN state and logic are absent; exhaustion always goes to FAIL.

Decomposition:
- Shared package snake_pkg:
  - coord_t (logic [9:0])
  - state enum spawn_state_t {IDLE, SAMPLE_X, SAMPLE_Y, QUERY, WAIT, SCAN, FAIL}
  - default GRID_W/GRID_H constants shared with the renderer
- Optional sub-module raster_step: combinational next-cell with wrap, used by SCAN.
- random10 is instantiated by the parent, not inside this block.

Test Plan:
- Fast path: GRID 40x30, rnd forced to 5 then 7, occ_ack with hit=0 one cycle after occ_req → done/done_ok=1 at cycle 5 after req, food=(5,7).
- Rejection: rnd sequence 45,900,12,31,3 → cand=(12,3). Values 31 (≥ GRID_H), 45 and 900 are rejected; occ_x=12, occ_y=3.
- Retry and exhaustion: MAX_TRIES=4, occ_hit=1 always, macro off → exactly 4 occ_req handshakes, then done=1, done_ok=0; food_x/food_y keep previous values.
- Scan fallback: macro on, 3x2 grid, MAX_TRIES=1, random candidate (2,1) hit, only (1,0) free → scan queries (0,0), then (1,0), then done_ok=1 with food=(1,0).
- Handshake hold: delay occ_ack 7 cycles → occ_req, occ_x, occ_y stable all 7 cycles. Stray occ_ack in IDLE → no state change.
- Reset mid-WAIT: assert rst low during WAIT → occ_req=0, busy=0 asynchronously; no done pulse after release.
